// File: rtl/alu_rr_sched.sv
// alu_rr_sched
//   Round-robin scheduler that shares one external combinational 4-bit ALU
//   between two requesters (R0, R1). A granted request is registered onto
//   the ALU inputs, the ALU result is captured one cycle later, and the
//   result is held on the response channel of the granted requester until
//   that requester accepts it.
//
// Ports
//   clk, rst               system clock, synchronous active-high reset
//   req{0,1}_valid/ready   request handshake (ready only in IDLE)
//   req{0,1}_a/_b/_op      operands and opcode (00 ADD, 01 SUB, 10 NAND, 11 XOR)
//   resp{0,1}_valid/ready  response handshake, one channel active at a time
//   resp_data, resp_err    captured ALU result / error, shared by both channels
//   alu_in1/in2/opcode     registered drive to the external ALU
//   alu_out, alu_error     external ALU result and error flag
//   busy                   high whenever a transaction is in flight
//   err_count              saturating count of completed error responses
//
// Build option
//   ALU_RR_SCHED_ERRCNT_EN  when defined, err_count is a live saturating
//                           counter; otherwise it is tied to zero.
//
// state | meaning
// IDLE  | waiting for a request, req ready driven from arbitration
// EXEC  | ALU inputs stable, result captured on the next edge
// RESP  | result presented to the granted requester until accepted

module alu_rr_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [3:0] resp_data,
  output logic       resp_err,
  output logic [3:0] alu_in1,
  output logic [3:0] alu_in2,
  output logic [1:0] alu_opcode,
  input  logic [3:0] alu_out,
  input  logic       alu_error,
  output logic       busy,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   prio;
  logic   gnt;

  logic   any_req;
  logic   sel;
  logic   resp_hs;

  // sel picks R1 when only R1 asks, or when both ask and R1 holds priority
  always_comb begin
    any_req = req0_valid | req1_valid;
    sel     = (req0_valid && req1_valid) ? prio : req1_valid;
    resp_hs = (state == RESP) && (gnt ? resp1_ready : resp0_ready);
  end

  assign req0_ready  = (state == IDLE) && any_req && !sel;
  assign req1_ready  = (state == IDLE) && any_req &&  sel;
  assign resp0_valid = (state == RESP) && !gnt;
  assign resp1_valid = (state == RESP) &&  gnt;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      gnt        <= 1'b0;
      alu_in1    <= 4'h0;
      alu_in2    <= 4'h0;
      alu_opcode <= 2'b00;
      resp_data  <= 4'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= sel;
            alu_in1    <= sel ? req1_a  : req0_a;
            alu_in2    <= sel ? req1_b  : req0_b;
            alu_opcode <= sel ? req1_op : req0_op;
            state      <= EXEC;
          end
        end
        EXEC: begin
          resp_data <= alu_out;
          resp_err  <= alu_error;
          state     <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            prio  <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_RR_SCHED_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'h00;
    end else if (resp_hs && resp_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: a combinational ALU model drives alu_out /
// alu_error from the DUT's ALU inputs, and a transaction-level reference
// (pending transaction, its age in cycles, priority, error tally) predicts
// every observable output each cycle.

module tb_alu_rr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       resp0_valid, resp1_valid;
  logic       resp0_ready, resp1_ready;
  logic [3:0] resp_data;
  logic       resp_err;
  logic [3:0] alu_in1, alu_in2;
  logic [1:0] alu_opcode;
  logic [3:0] alu_out;
  logic       alu_error;
  logic       busy;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_error(alu_error),
    .busy(busy), .err_count(err_count)
  );

  // ALU: {error, result}; error is signed overflow on ADD/SUB
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    logic [3:0] r;
    logic       e;
    e = 1'b0;
    case (op)
      2'b00: begin r = a + b; e = (a[3] == b[3]) && (r[3] != a[3]); end
      2'b01: begin r = a - b; e = (a[3] != b[3]) && (r[3] != a[3]); end
      2'b10: r = ~(a & b);
      default: r = a ^ b;
    endcase
    return {e, r};
  endfunction

  assign {alu_error, alu_out} = alu_fn(alu_in1, alu_in2, alu_opcode);

  // reference model state
  bit         m_pend;
  bit         m_ch;
  int         m_age;
  bit         m_prio;
  logic [3:0] m_in1, m_in2, m_data;
  logic [1:0] m_op;
  logic       m_err;
  int         m_errs;

  task automatic model_reset();
    m_pend = 0; m_ch = 0; m_age = 0; m_prio = 0;
    m_in1 = 0; m_in2 = 0; m_op = 0; m_data = 0; m_err = 0; m_errs = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_errcnt();
`ifdef ALU_RR_SCHED_ERRCNT_EN
    return (m_errs > 255) ? 8'hFF : 8'(m_errs);
`else
    return 8'h00;
`endif
  endfunction

  // one clock cycle: apply inputs, check outputs at negedge, advance the model
  task automatic step(input bit r,
                      input bit v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] o0,
                      input bit v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] o1,
                      input bit rr0, input bit rr1);
    bit g;
    bit any;
    logic [4:0] res;
    rst = r;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    resp0_ready = rr0; resp1_ready = rr1;
    @(negedge clk);
    any = v0 | v1;
    g   = (v0 && v1) ? m_prio : v1;
    chk("req0_ready",  {7'd0, req0_ready},  {7'd0, !m_pend && any && !g});
    chk("req1_ready",  {7'd0, req1_ready},  {7'd0, !m_pend && any && g});
    chk("resp0_valid", {7'd0, resp0_valid}, {7'd0, m_pend && m_age >= 1 && !m_ch});
    chk("resp1_valid", {7'd0, resp1_valid}, {7'd0, m_pend && m_age >= 1 && m_ch});
    chk("busy",        {7'd0, busy},        {7'd0, m_pend});
    chk("resp_data",   {4'd0, resp_data},   {4'd0, m_data});
    chk("resp_err",    {7'd0, resp_err},    {7'd0, m_err});
    chk("alu_in1",     {4'd0, alu_in1},     {4'd0, m_in1});
    chk("alu_in2",     {4'd0, alu_in2},     {4'd0, m_in2});
    chk("alu_opcode",  {6'd0, alu_opcode},  {6'd0, m_op});
    chk("err_count",   err_count,           exp_errcnt());
    if (r) begin
      model_reset();
    end else if (!m_pend) begin
      if (any) begin
        m_pend = 1; m_ch = g; m_age = 0;
        m_in1 = g ? a1 : a0; m_in2 = g ? b1 : b0; m_op = g ? o1 : o0;
      end
    end else if (m_age == 0) begin
      res = alu_fn(m_in1, m_in2, m_op);
      m_data = res[3:0]; m_err = res[4]; m_age = 1;
    end else if (m_ch ? rr1 : rr0) begin
      m_pend = 0;
      m_prio = ~m_ch;
      if (m_err) m_errs++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rr0, input bit rr1);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, rr0, rr1);
  endtask

  initial begin
    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    resp0_ready = 0; resp1_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    idle(2, 1, 1);

    // R0 only: 0111 + 0001 -> 1000, overflow
    step(0, 1, 4'b0111, 4'b0001, 2'b00, 0, 0, 0, 0, 1, 0);
    idle(3, 1, 0);

    // R1 only: 0011 - 0101 -> 1110, no overflow
    step(0, 0, 0, 0, 0, 1, 4'b0011, 4'b0101, 2'b01, 0, 1);
    idle(3, 0, 1);

    // both valid continuously: grants alternate
    for (int i = 0; i < 12; i++)
      step(0, 1, 4'b1010, 4'b0110, 2'b11, 1, 4'b0010, 4'b0011, 2'b00, 1, 1);
    idle(3, 1, 1);

    // backpressure on R0 for 5 cycles in RESP, requests pending meanwhile
    step(0, 1, 4'b1100, 4'b0101, 2'b10, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step(0, 1, 4'b0001, 4'b0001, 2'b00, 1, 4'b0001, 4'b0001, 2'b00, 0, 1);
    idle(3, 1, 1);

    // reset during EXEC: transaction dropped, prio back to R0
    step(0, 0, 0, 0, 0, 1, 4'b0101, 4'b0110, 2'b00, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3, 1, 1);
    for (int i = 0; i < 4; i++)
      step(0, 1, 4'b0011, 4'b0011, 2'b01, 1, 4'b1111, 4'b0001, 2'b00, 1, 1);
    idle(3, 1, 1);

    // randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom));

    // error counter saturation: 260 overflowing ADDs from R0
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 780; i++)
      step(0, 1, 4'b0111, 4'b0111, 2'b00, 0, 0, 0, 0, 1, 0);
    idle(3, 1, 1);
`ifdef ALU_RR_SCHED_ERRCNT_EN
    chk("err_count_final", err_count, 8'hFF);
`else
    chk("err_count_final", err_count, 8'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
